// File: rtl/bht_port_arbiter_pkg.sv
// Shared types for the BHT port arbiter: counter encoding, queued update record, FSM states.
package bht_port_arbiter_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_ctr_t;

  localparam int BHT_IDX_W = 6;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    bht_ctr_t             ctr;
  } bht_upd_t;

  localparam bht_ctr_t BHT_CTR_INIT = WNT;

  typedef enum logic {
    ARB_INIT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_t;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic bht_ctr_t bht_next_ctr(input bht_ctr_t old, input logic taken);
    logic [1:0] o;
    o = old;
    if (taken) return (o == 2'd3) ? ST  : bht_ctr_t'(o + 2'd1);
    else       return (o == 2'd0) ? SNT : bht_ctr_t'(o - 2'd1);
  endfunction

endpackage

// File: rtl/bht_update_fifo.sv
// Update FIFO for the BHT arbiter; exposes every entry in age order (0 = head) with valid bits.
module bht_update_fifo
  import bht_port_arbiter_pkg::*;
#(
  parameter type T     = bht_upd_t,
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              entries [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[rd_ptr + PW'(i)];
      valid[i]   = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/bht_port_arbiter.sv
// Owns the single BHT array port: post-reset init sweep, then lookup/update arbitration
// with update queueing and forwarding. Optional statistics counters under BHT_STATS_EN.
//
// state    | meaning
// ARB_INIT | sweep every entry to weakly-not-taken, no requests accepted
// ARB_RUN  | full queue drains first, else lookup, else drain, else idle
module bht_port_arbiter
  import bht_port_arbiter_pkg::*;
#(
  parameter int  IDX_WIDTH = BHT_IDX_W,
  parameter int  UQ_DEPTH  = 4,
  localparam int CW        = $clog2(UQ_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lk_valid,
  input  logic [IDX_WIDTH-1:0] lk_idx,
  output logic                 lk_ready,
  output logic                 lk_rvalid,
  output logic [1:0]           lk_ctr,
  output logic                 lk_taken,
  input  logic                 up_valid,
  input  logic [IDX_WIDTH-1:0] up_idx,
  input  logic [1:0]           up_old_ctr,
  input  logic                 up_taken,
  output logic                 up_ready,
  output logic                 arr_en,
  output logic                 arr_we,
  output logic [IDX_WIDTH-1:0] arr_addr,
  output logic [1:0]           arr_wdata,
  input  logic [1:0]           arr_rdata,
`ifdef BHT_STATS_EN
  output logic [31:0]          num_updates,
  output logic [31:0]          num_mispredicts,
  output logic [31:0]          num_full_stall,
`endif
  output logic [CW-1:0]        q_count
);

  typedef struct packed {
    logic [IDX_WIDTH-1:0] idx;
    bht_ctr_t             ctr;
  } upd_t;

  arb_state_t           state, state_n;
  logic [IDX_WIDTH-1:0] ptr;
  upd_t                 q_entries [UQ_DEPTH];
  logic [UQ_DEPTH-1:0]  q_valid;
  upd_t                 push_data;
  logic                 push, pop;
  logic                 q_full, q_empty;
  logic                 fwd_hit, fwd_hit_q;
  bht_ctr_t             fwd_ctr, fwd_ctr_q;
  logic [1:0]           ctr_hold;

  bht_update_fifo #(.T(upd_t), .DEPTH(UQ_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .entries   (q_entries),
    .valid     (q_valid),
    .count     (q_count)
  );

  assign q_full        = (q_count == CW'(UQ_DEPTH));
  assign q_empty       = (q_count == '0);
  assign push_data.idx = up_idx;
  assign push_data.ctr = bht_next_ctr(bht_ctr_t'(up_old_ctr), up_taken);
  assign push          = up_valid && up_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_INIT;
      ptr   <= '0;
    end else begin
      state <= state_n;
      if (state == ARB_INIT) ptr <= ptr + IDX_WIDTH'(1);
    end
  end

  always_comb begin
    state_n   = state;
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = '0;
    arr_wdata = '0;
    lk_ready  = 1'b0;
    up_ready  = 1'b0;
    pop       = 1'b0;
    case (state)
      ARB_INIT: begin
        arr_en    = 1'b1;
        arr_we    = 1'b1;
        arr_addr  = ptr;
        arr_wdata = BHT_CTR_INIT;
        if (ptr == {IDX_WIDTH{1'b1}}) state_n = ARB_RUN;
      end
      ARB_RUN: begin
        up_ready = !q_full;
        if (q_full || (!lk_valid && !q_empty)) begin
          arr_en    = 1'b1;
          arr_we    = 1'b1;
          arr_addr  = q_entries[0].idx;
          arr_wdata = q_entries[0].ctr;
          pop       = 1'b1;
        end else if (lk_valid) begin
          arr_en   = 1'b1;
          arr_addr = lk_idx;
          lk_ready = 1'b1;
        end
      end
      default: state_n = ARB_INIT;
    endcase
    // Reset is asynchronous, so the port must be quiet combinationally while it is held.
    if (rst) begin
      arr_en   = 1'b0;
      lk_ready = 1'b0;
      up_ready = 1'b0;
      pop      = 1'b0;
    end
  end

  // Newest match wins: later queue slots override earlier, same-cycle enqueue overrides all.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_ctr = SNT;
    for (int i = 0; i < UQ_DEPTH; i++) begin
      if (q_valid[i] && (q_entries[i].idx == lk_idx)) begin
        fwd_hit = 1'b1;
        fwd_ctr = q_entries[i].ctr;
      end
    end
    if (push && (push_data.idx == lk_idx)) begin
      fwd_hit = 1'b1;
      fwd_ctr = push_data.ctr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_rvalid <= 1'b0;
      fwd_hit_q <= 1'b0;
      fwd_ctr_q <= SNT;
      ctr_hold  <= '0;
    end else begin
      lk_rvalid <= lk_ready;
      if (lk_ready) begin
        fwd_hit_q <= fwd_hit;
        fwd_ctr_q <= fwd_ctr;
      end
      if (lk_rvalid) ctr_hold <= lk_ctr;
    end
  end

  assign lk_ctr   = lk_rvalid ? (fwd_hit_q ? fwd_ctr_q : arr_rdata) : ctr_hold;
  assign lk_taken = lk_ctr[1];

`ifdef BHT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_updates     <= '0;
      num_mispredicts <= '0;
      num_full_stall  <= '0;
    end else begin
      if (push) num_updates <= num_updates + 32'd1;
      if (push && (up_old_ctr[1] != up_taken)) num_mispredicts <= num_mispredicts + 32'd1;
      if ((state == ARB_RUN) && q_full) num_full_stall <= num_full_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bht_port_arbiter.sv
// Randomized and directed bench for bht_port_arbiter against a table-level reference model.
module tb_bht_port_arbiter;

  localparam int IW = 6;
  localparam int UQ = 4;
  localparam int N  = 1 << IW;
  localparam int CW = $clog2(UQ) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          lk_valid;
  logic [IW-1:0] lk_idx;
  logic          lk_ready, lk_rvalid, lk_taken;
  logic [1:0]    lk_ctr;
  logic          up_valid;
  logic [IW-1:0] up_idx;
  logic [1:0]    up_old_ctr;
  logic          up_taken, up_ready;
  logic          arr_en, arr_we;
  logic [IW-1:0] arr_addr;
  logic [1:0]    arr_wdata, arr_rdata;
  logic [CW-1:0] q_count;
`ifdef BHT_STATS_EN
  logic [31:0]   num_updates, num_mispredicts, num_full_stall;
`endif

  always #5 clk = ~clk;

  bht_port_arbiter #(.IDX_WIDTH(IW), .UQ_DEPTH(UQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .lk_valid   (lk_valid),
    .lk_idx     (lk_idx),
    .lk_ready   (lk_ready),
    .lk_rvalid  (lk_rvalid),
    .lk_ctr     (lk_ctr),
    .lk_taken   (lk_taken),
    .up_valid   (up_valid),
    .up_idx     (up_idx),
    .up_old_ctr (up_old_ctr),
    .up_taken   (up_taken),
    .up_ready   (up_ready),
    .arr_en     (arr_en),
    .arr_we     (arr_we),
    .arr_addr   (arr_addr),
    .arr_wdata  (arr_wdata),
    .arr_rdata  (arr_rdata),
`ifdef BHT_STATS_EN
    .num_updates     (num_updates),
    .num_mispredicts (num_mispredicts),
    .num_full_stall  (num_full_stall),
`endif
    .q_count    (q_count)
  );

  // Array model: one port, read data one cycle after a read.
  logic [1:0] ram [N];
  logic [1:0] rdata_q;
  always @(posedge clk) begin
    if (arr_en && arr_we) ram[arr_addr] <= arr_wdata;
    if (arr_en && !arr_we) rdata_q <= ram[arr_addr];
  end
  assign arr_rdata = rdata_q;

  typedef struct {int idx; int ctr;} ent_t;
  ent_t mq[$];
  int   view [N];
  int   exp_rvalid, exp_ctr, exp_hold;
  int   m_upd, m_mis, m_stall;
  int   checks, failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_rvalid = 0; exp_ctr = 0; exp_hold = 0;
    m_upd = 0; m_mis = 0; m_stall = 0;
  endtask

  task automatic check_in_reset();
    check("rst_arr_en", arr_en, 0);
    check("rst_lk_ready", lk_ready, 0);
    check("rst_up_ready", up_ready, 0);
    check("rst_q_count", q_count, 0);
    check("rst_lk_rvalid", lk_rvalid, 0);
    check("rst_lk_ctr", lk_ctr, 0);
  endtask

  task automatic run_init();
    for (int i = 0; i < N; i++) begin
      lk_valid = 1'($urandom_range(0, 1));
      lk_idx   = IW'($urandom_range(0, N - 1));
      up_valid = 1'($urandom_range(0, 1));
      up_idx   = IW'($urandom_range(0, N - 1));
      @(negedge clk);
      check("init_arr_en", arr_en, 1);
      check("init_arr_we", arr_we, 1);
      check("init_arr_addr", arr_addr, i);
      check("init_arr_wdata", arr_wdata, 1);
      check("init_lk_ready", lk_ready, 0);
      check("init_up_ready", up_ready, 0);
      check("init_q_count", q_count, 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) view[i] = 1;
  endtask

  task automatic step(input int lv, input int li, input int uv, input int ui, input int uo, input int ut);
    bit full, drain, elr, eur;
    int nc;
    lk_valid = 1'(lv); lk_idx = IW'(li);
    up_valid = 1'(uv); up_idx = IW'(ui); up_old_ctr = 2'(uo); up_taken = 1'(ut);
    @(negedge clk);
    check("lk_rvalid", lk_rvalid, exp_rvalid);
    if (exp_rvalid != 0) begin
      check("lk_ctr", lk_ctr, exp_ctr);
      check("lk_taken", lk_taken, exp_ctr / 2);
    end else begin
      check("lk_ctr_hold", lk_ctr, exp_hold);
    end
    full  = (mq.size() == UQ);
    eur   = !full;
    elr   = !full && (lv != 0);
    drain = full || ((lv == 0) && (mq.size() > 0));
    check("q_count", q_count, mq.size());
    check("up_ready", up_ready, eur);
    check("lk_ready", lk_ready, elr);
    if (drain) begin
      check("drain_en", arr_en, 1);
      check("drain_we", arr_we, 1);
      check("drain_addr", arr_addr, mq[0].idx);
      check("drain_wdata", arr_wdata, mq[0].ctr);
    end else if (lv != 0) begin
      check("read_en", arr_en, 1);
      check("read_we", arr_we, 0);
      check("read_addr", arr_addr, li);
    end else begin
      check("idle_en", arr_en, 0);
    end
    if (full) m_stall++;
    if (drain) void'(mq.pop_front());
    if (eur && (uv != 0)) begin
      nc = (ut != 0) ? ((uo == 3) ? 3 : uo + 1) : ((uo == 0) ? 0 : uo - 1);
      view[ui] = nc;
      mq.push_back('{idx: ui, ctr: nc});
      m_upd++;
      if ((uo / 2) != ut) m_mis++;
    end
    if (exp_rvalid != 0) exp_hold = exp_ctr;
    exp_rvalid = elr ? 1 : 0;
    if (elr) exp_ctr = view[li];
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_stats();
`ifdef BHT_STATS_EN
    check("num_updates", num_updates, m_upd);
    check("num_mispredicts", num_mispredicts, m_mis);
    check("num_full_stall", num_full_stall, m_stall);
`endif
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < N; i++) ram[i] = 2'b11;
    rdata_q = 2'b00;
    rst = 1'b1;
    lk_valid = 1'b1; lk_idx = '0; up_valid = 1'b1; up_idx = '0; up_old_ctr = '0; up_taken = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_in_reset();
    rst = 1'b0;
    run_init();

    // Post-init lookup, plain update, saturation.
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 1, 9, 1, 1);
    idle(1);
    step(1, 9, 0, 0, 0, 0);
    step(0, 0, 1, 10, 3, 1);
    step(0, 0, 1, 11, 0, 0);
    step(1, 10, 0, 0, 0, 0);
    step(1, 11, 0, 0, 0, 0);
    idle(1);

    // Lookups every cycle while updates fill the queue.
    for (int k = 0; k < 4; k++) step(1, 20 + k, 1, 30 + k, k, k % 2);
    step(1, 1, 1, 40, 1, 1);
    step(1, 2, 1, 41, 2, 0);
    step(1, 3, 1, 42, 0, 1);
    idle(6);

    // Forwarding from the queue, then from a same-cycle enqueue.
    step(1, 0, 1, 7, 1, 1);
    step(1, 0, 1, 7, 2, 1);
    step(1, 7, 0, 0, 0, 0);
    step(1, 7, 1, 7, 1, 0);
    idle(4);

    // Reset with three queued updates.
    step(1, 0, 1, 1, 1, 1);
    step(1, 0, 1, 2, 1, 0);
    step(1, 0, 1, 3, 2, 0);
    check("pre_rst_q_count", q_count, 3);
    rst = 1'b1;
    #1;
    check_in_reset();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    run_init();

    step(0, 0, 1, 4, 0, 0);
    step(0, 0, 1, 5, 2, 1);
    step(0, 0, 1, 6, 1, 1);
    idle(4);
    check_stats();

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 3), $urandom_range(0, 1));
    end
    idle(6);
    check_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bht_port_arbiter.md
Name: bht_port_arbiter

Overview:
- Owns the single read/write port of the branch history table (BHT) array, a table of 2-bit saturating counters.
- Shares that port between two requesters: fetch-stage lookups and resolve-stage counter updates.
- Buffers updates in a small queue and forwards pending updates to matching lookups.
- Runs a post-reset init sweep so every counter starts weakly-not-taken.

Parameters:
- IDX_WIDTH, 6, BHT index width; table has 2**IDX_WIDTH entries
- UQ_DEPTH, 4, update queue depth (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- lk_valid  in  1  fetch lookup request
- lk_idx  in  IDX_WIDTH  lookup index
- lk_ready  out  1  lookup accepted this cycle
- lk_rvalid  out  1  lookup result valid
- lk_ctr  out  2  counter for accepted lookup
- lk_taken  out  1  lk_ctr[1]
- up_valid  in  1  resolved branch/jump update
- up_idx  in  IDX_WIDTH  update index
- up_old_ctr  in  2  counter value carried from prediction
- up_taken  in  1  actual outcome
- up_ready  out  1  update accepted
- arr_en  out  1  array access enable
- arr_we  out  1  array write
- arr_addr  out  IDX_WIDTH  array address
- arr_wdata  out  2  array write data
- arr_rdata  in  2  array read data, valid 1 cycle after read
- q_count  out  $clog2(UQ_DEPTH)+1  queue occupancy

Behaviour:
- Reset (async): state=INIT, init pointer=0, queue empty, lk_rvalid=0, lk_ctr=0. While rst is high, arr_en=0, lk_ready=0 and up_ready=0. Reset mid-operation discards queued updates and any in-flight lookup result.
- FSM INIT:
  - Each cycle: arr_en=1, arr_we=1, arr_addr=ptr, arr_wdata=2'b01 (WNT); ptr++.
  - After writing entry 2**IDX_WIDTH-1, go to RUN.
  - lk_ready=0 and up_ready=0 throughout.
  - Total INIT length: 2**IDX_WIDTH cycles.
- FSM RUN arbitration, in priority order each cycle:
  1. Queue full: drain head (write); lk_ready=0.
  2. Otherwise, lk_valid: read lk_idx; lk_ready=1.
  3. Otherwise, queue non-empty: drain head.
  4. Otherwise: arr_en=0.
- RUN has no exit except reset.
- Update enqueue:
  - up_ready = (state==RUN) && (count<UQ_DEPTH). When full, up_ready stays 0 even in a cycle that drains.
  - On up_valid && up_ready, enqueue {up_idx, new_ctr}.
  - new_ctr = up_taken ? sat_inc(up_old_ctr) : sat_dec(up_old_ctr). sat_inc(3)=3, sat_dec(0)=0.
  - Enqueue and drain may happen in the same cycle; count is then unchanged.
- Drain: arr_we=1, arr_addr=head.idx, arr_wdata=head.ctr; pop the head.
- Lookup result:
  - lk_rvalid=1 exactly one cycle after lk_ready=1; 0 otherwise.
  - lk_ctr defaults to arr_rdata.
  - Forwarding: at accept, compare lk_idx against all queued entries plus any same-cycle enqueue. If any match, register the newest matching ctr and present it next cycle instead of arr_rdata.
  - lk_ctr holds its value when lk_rvalid=0.
- Queue pointers wrap modulo UQ_DEPTH. Updates drain in FIFO order, so the last write to an index wins.

Optional Feature:
- BHT_STATS_EN defined: adds outputs num_updates and num_mispredicts (32-bit each, reset 0), plus num_full_stall (cycles in RUN with a full queue).
  - num_updates increments per accepted update.
  - num_mispredicts increments per accepted update where up_old_ctr[1] != up_taken.
  - Counters wrap at 2**32.
- BHT_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- rv32i_types gains:
  - enum bht_ctr_t: SNT=0, WNT=1, WT=2, ST=3
  - struct bht_upd_t: {idx, ctr}
  - localparam BHT_CTR_INIT=WNT
- Sub-module bht_update_fifo: parameterised FIFO of bht_upd_t that exposes all entries plus valid bits for the forwarding compare. The arbiter FSM, saturation logic and forwarding stay in the top.

Test Plan:
- Reset, idle → INIT runs 64 cycles writing 01 to addresses 0..63; lk_ready=0 and up_ready=0; then RUN. A lookup of idx 5 returns lk_ctr=01 the following cycle.
- Update idx 9, old=01, taken=1, no lookups → one write of 10 to addr 9 the next cycle; a later lookup of idx 9 returns 10.
- Saturation: update old=11 taken=1 → writes 11; old=00 taken=0 → writes 00.
- Lookup every cycle while 4 updates arrive → queue fills; next cycle lk_ready=0, head drains, up_ready=0; lk_ready=1 once count=3.
- Forwarding: queue holds idx 7→10 then idx 7→11; lookup idx 7 → lk_ctr=11 with no array read data used. Same-cycle enqueue of idx 7→00 with lookup idx 7 → 00.
- Assert rst mid-RUN with 3 queued updates → q_count=0, lk_rvalid=0, INIT restarts at ptr 0. With BHT_STATS_EN: 3 updates, 1 mispredicted → num_updates=3, num_mispredicts=1.
